// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern tester.
// Covers the FSM state encoding, bus widths and the LFSR tap mask.
package sdram_test_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 9;

    localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_INIT = 3'd1;
    localparam state_t ST_WR_REQ    = 3'd2;
    localparam state_t ST_WR_DATA   = 3'd3;
    localparam state_t ST_RD_REQ    = 3'd4;
    localparam state_t ST_RD_DATA   = 3'd5;
    localparam state_t ST_FINISH    = 3'd6;

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// Burst request/ack user interface between the pattern tester (master) and sdram_top (slave).
// An ack is a one-cycle strobe per word consumed or delivered; requests are held until the first ack.
interface sdram_pattern_tester_if;
    import sdram_test_pkg::*;

    logic              sdram_init_done;
    logic              sdram_wr_req;
    logic              sdram_wr_ack;
    logic              sdram_rd_req;
    logic              sdram_rd_ack;
    logic [ADDR_W-1:0] sys_wraddr;
    logic [ADDR_W-1:0] sys_rdaddr;
    logic [DATA_W-1:0] sys_data_in;
    logic [DATA_W-1:0] sys_data_out;
    logic [LEN_W-1:0]  sdwr_byte;
    logic [LEN_W-1:0]  sdrd_byte;

    modport master (
        input  sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
        output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sys_data_in,
        sdwr_byte, sdrd_byte
    );

    modport slave (
        output sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
        input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sys_data_in,
        sdwr_byte, sdrd_byte
    );

endinterface

// File: rtl/sdram_pattern_gen.sv
// Word pattern source: load takes the seed, advance steps one word; value is a registered output.
// Incrementing by default; SDRAM_TEST_LFSR_EN selects a Galois LFSR (zero seed forced to 1).
module sdram_pattern_gen
    import sdram_test_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
`ifdef SDRAM_TEST_LFSR_EN
            value_d = (seed == '0) ? 16'h0001 : seed;
`else
            value_d = seed;
`endif
        end else if (advance) begin
`ifdef SDRAM_TEST_LFSR_EN
            value_d = {1'b0, value_q[DATA_W-1:1]} ^ (value_q[0] ? LFSR_TAPS : '0);
`else
            value_d = value_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/sdram_pattern_tester.sv
// Writes a seeded pattern over NUM_BURSTS*BURST_LEN words, reads it back and tallies mismatches.
// Pattern source is incrementing unless SDRAM_TEST_LFSR_EN is defined; a watchdog aborts stalled bursts.
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     seed,
    sdram_pattern_tester_if.master sd,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [DATA_W-1:0]     err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [DATA_W-1:0]     first_err_data
);

    localparam int BW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WDT_W = $clog2(TIMEOUT + 1);

    localparam logic [LEN_W-1:0]  LAST_WORD  = LEN_W'(BURST_LEN - 1);
    localparam logic [BW-1:0]     LAST_BURST = BW'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [WDT_W-1:0]  WDT_LAST   = WDT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    word_q, word_d;
    logic [WDT_W-1:0]    wdt_q, wdt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;

    logic                gen_load, wr_adv, rd_adv;
    logic                in_wr, in_rd, wr_hit, rd_hit;
    logic [DATA_W-1:0]   wr_val, rd_val;

    // Independent writer and checker sources; both load at start so the read pass replays the seed.
    sdram_pattern_gen u_wr_gen (
        .clk(clk), .reset(reset), .load(gen_load), .advance(wr_adv), .seed(seed), .value(wr_val)
    );

    sdram_pattern_gen u_rd_gen (
        .clk(clk), .reset(reset), .load(gen_load), .advance(rd_adv), .seed(seed), .value(rd_val)
    );

    assign in_wr  = (state_q == ST_WR_REQ) || (state_q == ST_WR_DATA);
    assign in_rd  = (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    assign wr_hit = in_wr && sd.sdram_wr_ack;
    assign rd_hit = in_rd && sd.sdram_rd_ack;

    always_comb begin
        state_d          = state_q;
        burst_d          = burst_q;
        base_d           = base_q;
        word_d           = word_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        gen_load         = 1'b0;
        wr_adv           = 1'b0;
        rd_adv           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d          = ST_WAIT_INIT;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    gen_load         = 1'b1;
                end
            end
            ST_WAIT_INIT: begin
                if (sd.sdram_init_done) begin
                    state_d = ST_WR_REQ;
                    burst_d = '0;
                    base_d  = '0;
                    word_d  = '0;
                end
            end
            ST_WR_REQ, ST_WR_DATA: begin
                if (wr_hit) begin
                    wr_adv = 1'b1;
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = ST_RD_REQ;
                            burst_d = '0;
                            base_d  = '0;
                        end else begin
                            state_d = ST_WR_REQ;
                            burst_d = burst_q + 1'b1;
                            base_d  = base_q + BURST_STEP;
                        end
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = ST_WR_DATA;
                    end
                end else if (wdt_q == WDT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_RD_REQ, ST_RD_DATA: begin
                if (rd_hit) begin
                    rd_adv = 1'b1;
                    if (sd.sys_data_out != rd_val) begin
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        if (err_count_q == '0) begin
                            first_err_addr_d = base_q + {{(ADDR_W-LEN_W){1'b0}}, word_q};
                            first_err_data_d = sd.sys_data_out;
                        end
                    end
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_RD_REQ;
                            burst_d = burst_q + 1'b1;
                            base_d  = base_q + BURST_STEP;
                        end
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = ST_RD_DATA;
                    end
                end else if (wdt_q == WDT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count_q == '0) && !timeout_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog measures idle cycles inside one state; any ack or state change restarts it.
        if ((state_d != state_q) || wr_hit || rd_hit) wdt_d = '0;
        else if (in_wr || in_rd)                      wdt_d = wdt_q + 1'b1;
        else                                          wdt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            burst_q          <= '0;
            base_q           <= '0;
            word_q           <= '0;
            wdt_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            state_q          <= state_d;
            burst_q          <= burst_d;
            base_q           <= base_d;
            word_q           <= word_d;
            wdt_q            <= wdt_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    // Requests decode straight from the state flop so reset removes them without a clock.
    assign sd.sdram_wr_req = (state_q == ST_WR_REQ);
    assign sd.sdram_rd_req = (state_q == ST_RD_REQ);
    assign sd.sys_wraddr   = base_q;
    assign sd.sys_rdaddr   = base_q;
    assign sd.sys_data_in  = wr_val;
    assign sd.sdwr_byte    = LEN_W'(BURST_LEN);
    assign sd.sdrd_byte    = LEN_W'(BURST_LEN);

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;

endmodule
